// File: rtl/host_rd_credit_ctrl_if.sv
// Request handshake bundle: upstream host request (s_req_*) and
// downstream chunk request (m_req_*). The slave modport is the
// credit controller's view; master is the host/fabric side.
interface host_rd_credit_ctrl_if #(
    parameter int CTL_W = 32
);
    logic             s_req_valid;
    logic             s_req_ready;
    logic [47:0]      s_req_vaddr;
    logic [27:0]      s_req_len;
    logic [CTL_W-1:0] s_req_ctl;

    logic             m_req_valid;
    logic             m_req_ready;
    logic [47:0]      m_req_vaddr;
    logic [27:0]      m_req_len;
    logic [CTL_W-1:0] m_req_ctl;
    logic             m_req_last;

    modport slave (
        input  s_req_valid, s_req_vaddr, s_req_len, s_req_ctl, m_req_ready,
        output s_req_ready, m_req_valid, m_req_vaddr, m_req_len, m_req_ctl, m_req_last
    );

    modport master (
        output s_req_valid, s_req_vaddr, s_req_len, s_req_ctl, m_req_ready,
        input  s_req_ready, m_req_valid, m_req_vaddr, m_req_len, m_req_ctl, m_req_last
    );
endinterface

// File: rtl/host_rd_credit_ctrl.sv
// Read-request splitter with beat-credit flow control. Each host request
// is cut into chunks of at most MAX_CHUNK bytes; a chunk is only issued
// once the downstream read-data FIFO has room for all of its beats.
//
// state | meaning
// IDLE  | waiting for a host request (s_req_ready=1)
// CHECK | computing next chunk, waiting for enough credits
// ISSUE | chunk presented on m_req, waiting for m_req_ready
module host_rd_credit_ctrl #(
    parameter int FIFO_DEPTH = 512,
    parameter int BEAT_BYTES = 64,
    parameter int MAX_CHUNK  = 4096,
    parameter int CTL_W      = 32
) (
    input  logic                          aclk,
    input  logic                          areset,
    host_rd_credit_ctrl_if.slave          bus,
    input  logic                          xfer,
    output logic [$clog2(FIFO_DEPTH):0]   credits,
    output logic                          credit_err
);
    localparam int CRED_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int BB_LOG2 = $clog2(BEAT_BYTES);
    localparam logic [CRED_W-1:0] DEPTH_C   = CRED_W'(FIFO_DEPTH);
    localparam logic [27:0]       MAX_C     = 28'(MAX_CHUNK);
    localparam logic [28:0]       BEAT_RND  = 29'(BEAT_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [47:0]        cur_vaddr;
    logic [27:0]        remaining;
    logic [CTL_W-1:0]   ctl;
    logic [47:0]        m_vaddr;
    logic [27:0]        m_len;
    logic [CTL_W-1:0]   m_ctl;
    logic               m_last;

    logic [27:0]        chunk;
    logic [28:0]        beats_sum;
    logic [CRED_W-1:0]  beats;
    logic               deduct;
    logic [CRED_W:0]    cred_sum;

    // Chunk size and beat count for the next chunk of the current request.
    always_comb begin
        chunk     = (remaining > MAX_C) ? MAX_C : remaining;
        beats_sum = {1'b0, chunk} + BEAT_RND;
        beats     = CRED_W'(beats_sum >> BB_LOG2);
        deduct    = (state == CHECK) && (credits >= beats);
        // One expression so a same-cycle deduction and pop net out exactly.
        cred_sum  = {1'b0, credits} - {1'b0, (deduct ? beats : '0)} + (CRED_W+1)'(xfer);
    end

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next      = state;
        bus.s_req_ready = 1'b0;
        bus.m_req_valid = 1'b0;
        unique case (state)
            IDLE: begin
                bus.s_req_ready = 1'b1;
                if (bus.s_req_valid)
                    state_next = (bus.s_req_len == 28'd0) ? IDLE : CHECK;
            end
            CHECK: begin
                if (deduct) state_next = ISSUE;
            end
            ISSUE: begin
                bus.m_req_valid = 1'b1;
                if (bus.m_req_ready) state_next = m_last ? IDLE : CHECK;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request tracking, chunk output registers and credit pool.
    always_ff @(posedge aclk) begin
        if (areset) begin
            cur_vaddr  <= '0;
            remaining  <= '0;
            ctl        <= '0;
            m_vaddr    <= '0;
            m_len      <= '0;
            m_ctl      <= '0;
            m_last     <= 1'b0;
            credits    <= DEPTH_C;
            credit_err <= 1'b0;
        end else begin
            if (state == IDLE && bus.s_req_valid) begin
                cur_vaddr <= bus.s_req_vaddr;
                remaining <= bus.s_req_len;
                ctl       <= bus.s_req_ctl;
            end
            if (deduct) begin
                m_vaddr <= cur_vaddr;
                m_len   <= chunk;
                m_ctl   <= ctl;
                m_last  <= (remaining == chunk);
            end
            if (state == ISSUE && bus.m_req_ready) begin
                cur_vaddr <= cur_vaddr + 48'(m_len);
                remaining <= remaining - m_len;
            end
            // Only an un-deducted pop at a full pool can exceed the depth.
            if (cred_sum > {1'b0, DEPTH_C}) begin
                credits    <= DEPTH_C;
                credit_err <= 1'b1;
            end else begin
                credits <= cred_sum[CRED_W-1:0];
            end
        end
    end

    assign bus.m_req_vaddr = m_vaddr;
    assign bus.m_req_len   = m_len;
    assign bus.m_req_ctl   = m_ctl;
    assign bus.m_req_last  = m_last;
endmodule

// File: tb/tb_host_rd_credit_ctrl.sv
// Directed bench for host_rd_credit_ctrl: reset, splitting, credit
// exhaustion, simultaneous deduct/pop, drop, overflow, wrap, mid-issue reset.
module tb_host_rd_credit_ctrl;
    logic        aclk = 1'b0;
    logic        areset;
    logic        xfer;
    logic [9:0]  credits;
    logic        credit_err;
    int          n_chk  = 0;
    int          n_fail = 0;
    int          lat;
    logic        seen;

    host_rd_credit_ctrl_if #(.CTL_W(32)) bus();

    host_rd_credit_ctrl #(
        .FIFO_DEPTH (512),
        .BEAT_BYTES (64),
        .MAX_CHUNK  (4096),
        .CTL_W      (32)
    ) dut (
        .aclk       (aclk),
        .areset     (areset),
        .bus        (bus),
        .xfer       (xfer),
        .credits    (credits),
        .credit_err (credit_err)
    );

    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge aclk);
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        xfer   = 1'b0;
        chk({tag, "_credits"}, credits, 512);
        chk({tag, "_s_ready"}, bus.s_req_ready, 1);
        chk({tag, "_m_valid"}, bus.m_req_valid, 0);
        chk({tag, "_err"}, credit_err, 0);
    endtask

    // Starts and ends on a negedge; returns just after the handshake edge.
    task automatic send_req(input logic [47:0] va, input logic [27:0] ln, input logic [31:0] c);
        bus.s_req_valid = 1'b1;
        bus.s_req_vaddr = va;
        bus.s_req_len   = ln;
        bus.s_req_ctl   = c;
        @(negedge aclk);
        bus.s_req_valid = 1'b0;
    endtask

    task automatic expect_chunk(input string tag, input logic [47:0] va, input logic [27:0] ln,
                                input logic lst, input int cr, output int n);
        n = 0;
        while (!bus.m_req_valid && n < 200) begin
            @(negedge aclk);
            n++;
        end
        chk({tag, "_valid"}, bus.m_req_valid, 1);
        chk({tag, "_vaddr"}, bus.m_req_vaddr, va);
        chk({tag, "_len"}, bus.m_req_len, ln);
        chk({tag, "_last"}, bus.m_req_last, lst);
        chk({tag, "_credits"}, credits, cr);
        @(negedge aclk);
    endtask

    initial begin
        areset          = 1'b1;
        xfer            = 1'b1;
        bus.s_req_valid = 1'b0;
        bus.s_req_vaddr = '0;
        bus.s_req_len   = '0;
        bus.s_req_ctl   = '0;
        bus.m_req_ready = 1'b1;

        // Reset with xfer held high throughout: pops must be ignored.
        do_reset("rst0");

        // Overflow: pop at a full pool saturates and sets the sticky flag.
        xfer = 1'b1;
        @(negedge aclk);
        xfer = 1'b0;
        chk("ovf_credits", credits, 512);
        chk("ovf_err", credit_err, 1);
        repeat (3) @(negedge aclk);
        chk("ovf_err_sticky", credit_err, 1);
        do_reset("rst1");

        // Split 10000 bytes into 4096/4096/1808.
        send_req(48'h1000, 28'd10000, 32'hA5A5_0001);
        chk("split_check_novalid", bus.m_req_valid, 0);
        expect_chunk("split0", 48'h1000, 28'd4096, 1'b0, 448, lat);
        chk("split0_lat", lat, 1);
        chk("split0_ctl", bus.m_req_ctl, 32'hA5A5_0001);
        expect_chunk("split1", 48'h2000, 28'd4096, 1'b0, 384, lat);
        chk("split1_lat", lat, 1);
        expect_chunk("split2", 48'h3000, 28'd1808, 1'b1, 355, lat);
        chk("split2_lat", lat, 1);
        chk("split_done_ready", bus.s_req_ready, 1);
        chk("split_end_credits", credits, 355);

        // Zero-length request is dropped.
        send_req(48'h8000, 28'd0, 32'h0);
        chk("drop_ready", bus.s_req_ready, 1);
        chk("drop_valid", bus.m_req_valid, 0);
        @(negedge aclk);
        chk("drop_valid2", bus.m_req_valid, 0);
        chk("drop_credits", credits, 355);

        // Exhaustion: 8 full chunks drain the pool.
        do_reset("rst2");
        for (int i = 0; i < 8; i++) begin
            send_req(48'(i) << 12, 28'd4096, 32'(i));
            expect_chunk($sformatf("exh%0d", i), 48'(i) << 12, 28'd4096, 1'b1, 448 - 64 * i, lat);
        end
        chk("exh_credits0", credits, 0);
        send_req(48'h9000, 28'd4096, 32'h9);
        seen = 1'b0;
        for (int i = 0; i < 64; i++) begin
            xfer = 1'b1;
            @(negedge aclk);
            seen = seen | bus.m_req_valid;
        end
        xfer = 1'b0;
        chk("exh_wait_novalid", seen, 0);
        chk("exh_credits64", credits, 64);
        expect_chunk("exh9", 48'h9000, 28'd4096, 1'b1, 0, lat);
        chk("exh9_lat", lat, 1);

        // Simultaneous pop and 64-beat deduction at credits=100.
        for (int i = 0; i < 100; i++) begin
            xfer = 1'b1;
            @(negedge aclk);
        end
        xfer = 1'b0;
        chk("sim_credits100", credits, 100);
        send_req(48'hA000, 28'd4096, 32'hA);
        xfer = 1'b1;
        @(negedge aclk);
        xfer = 1'b0;
        chk("sim_credits37", credits, 37);
        expect_chunk("sim", 48'hA000, 28'd4096, 1'b1, 37, lat);

        // Address wrap past 2^48-1 and a 65-byte tail needing 2 beats.
        do_reset("rst3");
        send_req(48'hFFFF_FFFF_F000, 28'd8257, 32'h5);
        expect_chunk("wrap0", 48'hFFFF_FFFF_F000, 28'd4096, 1'b0, 448, lat);
        expect_chunk("wrap1", 48'h0, 28'd4096, 1'b0, 384, lat);
        expect_chunk("wrap2", 48'h1000, 28'd65, 1'b1, 382, lat);

        // Reset while a chunk is stalled on m_req_ready.
        bus.m_req_ready = 1'b0;
        send_req(48'h5000, 28'd8192, 32'h7);
        @(negedge aclk);
        chk("mid_valid", bus.m_req_valid, 1);
        @(negedge aclk);
        chk("mid_hold_valid", bus.m_req_valid, 1);
        chk("mid_hold_vaddr", bus.m_req_vaddr, 48'h5000);
        chk("mid_hold_len", bus.m_req_len, 4096);
        areset = 1'b1;
        @(negedge aclk);
        areset = 1'b0;
        chk("mid_rst_valid", bus.m_req_valid, 0);
        chk("mid_rst_credits", credits, 512);
        chk("mid_rst_ready", bus.s_req_ready, 1);
        bus.m_req_ready = 1'b1;
        seen = 1'b0;
        repeat (6) begin
            @(negedge aclk);
            seen = seen | bus.m_req_valid;
        end
        chk("mid_no_more_chunks", seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/host_rd_credit_ctrl.md
HOST_RD_CREDIT_CTRL -- requirements
Module: host_rd_credit_ctrl

Interface
REQ-001 Parameters SHALL be:
- FIFO_DEPTH, 512: downstream read-data FIFO depth in beats.
- BEAT_BYTES, 64: bytes per data beat.
- MAX_CHUNK, 4096: maximum bytes per issued chunk; a power of two and a multiple of BEAT_BYTES.
- CTL_W, 32: width of the opaque control field.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- aclk, in, 1: clock.
- areset, in, 1: reset.
- s_req_valid, in, 1: request valid.
- s_req_ready, out, 1: request ready.
- s_req_vaddr, in, 48: start address.
- s_req_len, in, 28: length in bytes.
- s_req_ctl, in, CTL_W: opaque pass-through field.
- m_req_valid, out, 1: chunk valid.
- m_req_ready, in, 1: chunk ready.
- m_req_vaddr, out, 48: chunk address.
- m_req_len, out, 28: chunk length in bytes.
- m_req_ctl, out, CTL_W: copy of s_req_ctl.
- m_req_last, out, 1: final chunk of the request.
- xfer, in, 1: one beat popped from the downstream data FIFO.
- credits, out, clog2(FIFO_DEPTH)+1: free beat credits.
- credit_err, out, 1: sticky credit-overflow flag.
REQ-003 The block SHALL use one clock, aclk; reset SHALL be synchronous and active-high on areset.

Function
REQ-004 FSM states SHALL be IDLE, CHECK and ISSUE.
REQ-005 s_req_ready SHALL equal (state==IDLE).
- On s_req handshake, vaddr, len and ctl SHALL be latched into cur_vaddr, remaining and ctl.
- Next state SHALL be CHECK, or IDLE if len==0 (the request is dropped and produces no output).
REQ-006 In CHECK, the block SHALL compute:
- chunk = min(remaining, MAX_CHUNK).
- beats = ceil(chunk/BEAT_BYTES).
REQ-007 In CHECK with credits >= beats, the block SHALL in that same cycle:
- register m_req_vaddr=cur_vaddr, m_req_len=chunk, m_req_ctl=ctl and m_req_last=(remaining==chunk);
- deduct beats from credits;
- move to ISSUE.
Otherwise it SHALL stay in CHECK.
REQ-008 In ISSUE, m_req_valid SHALL be 1 and all m_req fields SHALL be held stable until m_req_ready.
- On handshake: cur_vaddr += chunk and remaining -= chunk.
- Next state SHALL be IDLE if m_req_last, else CHECK.
REQ-009 m_req_valid SHALL be 0 in IDLE and CHECK.
REQ-010 Minimum latency SHALL be: s_req handshake at cycle T, CHECK at T+1, m_req_valid at T+2. Each subsequent chunk SHALL be presented no earlier than 2 cycles after the previous m_req handshake.
REQ-011 The credit update SHALL be applied every cycle as credits_next = credits - (deduct ? beats : 0) + (xfer ? 1 : 0), evaluated in a single expression.
- A simultaneous deduction and xfer SHALL net correctly.
- The CHECK comparison SHALL use the registered credits value, not credits_next.
REQ-012 When xfer=1 and credits==FIFO_DEPTH with no deduction in that cycle:
- credits SHALL stay at FIFO_DEPTH (saturate);
- credit_err SHALL set and remain 1 until reset.
REQ-013 cur_vaddr arithmetic SHALL be 48-bit modulo; wrap past 2^48-1 is permitted and is not flagged.
REQ-014 credits SHALL never go below 0; this is guaranteed by the REQ-007 comparison.

Reset
REQ-015 While areset=1 at a rising edge, the block SHALL apply:
- state=IDLE;
- credits=FIFO_DEPTH;
- credit_err=0;
- m_req_valid=0;
- m_req_* data and m_req_last=0.
REQ-016 Reset during CHECK or ISSUE SHALL discard the in-flight request without emitting further chunks.
- s_req_ready SHALL be 1 in the first cycle after areset deasserts.
- xfer asserted during reset SHALL be ignored.

Verification
REQ-017 Reset check: assert areset for 2 cycles -> credits=512, s_req_ready=1, m_req_valid=0, credit_err=0.
REQ-018 Split check: request vaddr=0x1000, len=10000, m_req_ready=1, no xfer -> required response:
- chunks (0x1000, 4096, last=0), (0x2000, 4096, last=0), (0x3000, 1808, last=1);
- credits ending at 355 (512-64-64-29).
REQ-019 Exhaustion check: 8 requests of len=4096 with no xfer -> credits=0. A 9th request then waits in CHECK with m_req_valid=0 through 63 xfer pulses and issues one cycle after the 64th xfer.
REQ-020 Simultaneous check: credits=100 with xfer=1 in the same cycle as a 64-beat deduction -> credits=37 next cycle.
REQ-021 Drop and overflow checks:
- len=0 request -> no m_req_valid, and s_req_ready=1 again 1 cycle later;
- xfer at credits=512 -> credits stays 512 and credit_err=1 until reset.
REQ-022 Reset mid-ISSUE: assert areset while m_req_valid=1 and m_req_ready=0 -> m_req_valid=0 and credits=512 the next cycle, and no further chunks are emitted.
